// File: rtl/ps2_scancode_decoder.sv
// ps2_scancode_decoder: turns PS/2 Set-2 scan-code bytes into one key event per key action.
// Latency: 3 cycles from receiver ready to ev_valid for a final byte; one byte fetched per 3 cycles.
// Backpressure: fetching stops while an event waits in EMIT, so ev_ready low stalls the receiver FIFO.
//
// Ports:
//   clk, clrn                 clock, asynchronous active-low reset
//   ps2_data/ps2_ready        head byte and non-empty flag of the receiver FIFO
//   ps2_nextdata_n            one-cycle active-low pop strobe back to the receiver
//   ev_valid/ev_ready         event handshake; ev_code/ev_ext/ev_break/ev_mods are the event
//   err_cnt                   saturating count of malformed bytes
// Optional: define TYPEMATIC_FILTER_EN to drop auto-repeat makes of the key currently held.
module ps2_scancode_decoder #(
    parameter int ERR_W      = 8,
    parameter int PAUSE_SKIP = 7
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic [7:0]       ps2_data,
    input  logic             ps2_ready,
    output logic             ps2_nextdata_n,
    output logic             ev_valid,
    input  logic             ev_ready,
    output logic [7:0]       ev_code,
    output logic             ev_ext,
    output logic             ev_break,
    output logic [3:0]       ev_mods,
    output logic [ERR_W-1:0] err_cnt
);
    localparam int SKIP_W = (PAUSE_SKIP < 1) ? 1 : $clog2(PAUSE_SKIP + 1);

    typedef enum logic [1:0] {IDLE, POP, DECODE, EMIT} state_t;

    state_t            r_state;
    logic [7:0]        r_byte;
    logic              r_ext_pend;
    logic              r_brk_pend;
    logic [SKIP_W-1:0] r_skip;
    logic              r_shl, r_shr, r_ctl_l, r_ctl_r, r_alt_l, r_alt_r, r_caps;
    logic              r_pop_n;
    logic              r_ev_valid;
    logic [7:0]        r_ev_code;
    logic              r_ev_ext;
    logic              r_ev_break;
    logic [3:0]        r_ev_mods;
    logic [ERR_W-1:0]  r_err_cnt;

    state_t            w_state_nxt;
    logic              w_load_byte;
    logic              w_emit;
    logic              w_err;
    logic              w_clr_pfx;
    logic              w_set_ext;
    logic              w_set_brk;
    logic [SKIP_W-1:0] w_skip_nxt;
    logic              w_repeat;
    logic              w_make;
    logic              w_shl, w_shr, w_ctl_l, w_ctl_r, w_alt_l, w_alt_r, w_caps;

    assign w_make = ~r_brk_pend;

`ifdef TYPEMATIC_FILTER_EN
    logic [8:0] r_held_key;
    logic       r_held_vld;
    // Auto-repeat: a make of the key that is still held down.
    assign w_repeat = w_make && r_held_vld && (r_held_key == {r_ext_pend, r_byte});
`else
    assign w_repeat = 1'b0;
`endif

    // Next state and byte classification.
    always_comb begin
        w_state_nxt = r_state;
        w_load_byte = 1'b0;
        w_emit      = 1'b0;
        w_err       = 1'b0;
        w_clr_pfx   = 1'b0;
        w_set_ext   = 1'b0;
        w_set_brk   = 1'b0;
        w_skip_nxt  = r_skip;
        case (r_state)
            IDLE: begin
                if (ps2_ready) begin
                    w_load_byte = 1'b1;
                    w_state_nxt = POP;
                end
            end
            POP:  w_state_nxt = DECODE;
            DECODE: begin
                w_state_nxt = IDLE;
                if (r_skip != '0) begin
                    // Inside a Pause/Break sequence: swallow the byte whatever it is.
                    w_skip_nxt = r_skip - 1'b1;
                end else if (r_byte == 8'hE1) begin
                    w_skip_nxt = SKIP_W'(PAUSE_SKIP);
                    w_clr_pfx  = 1'b1;
                end else if (r_byte == 8'hE0) begin
                    w_set_ext = 1'b1;
                    w_err     = r_ext_pend | r_brk_pend;
                end else if (r_byte == 8'hF0) begin
                    w_set_brk = 1'b1;
                    w_err     = r_brk_pend;
                end else if ((r_byte == 8'h00) || (r_byte == 8'hFF)) begin
                    w_clr_pfx = 1'b1;
                    w_err     = 1'b1;
                end else if ((r_byte == 8'hAA) || (r_byte == 8'hFA)) begin
                    w_clr_pfx = 1'b1;
                end else begin
                    w_clr_pfx = 1'b1;
                    if (!w_repeat) begin
                        w_emit      = 1'b1;
                        w_state_nxt = EMIT;
                    end
                end
            end
            EMIT: begin
                if (ev_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Modifier state as it will be after the current byte, applied only when an event is emitted.
    always_comb begin
        w_shl   = r_shl;
        w_shr   = r_shr;
        w_ctl_l = r_ctl_l;
        w_ctl_r = r_ctl_r;
        w_alt_l = r_alt_l;
        w_alt_r = r_alt_r;
        w_caps  = r_caps;
        if (r_byte == 8'h12 && !r_ext_pend) w_shl = w_make;
        if (r_byte == 8'h59 && !r_ext_pend) w_shr = w_make;
        if (r_byte == 8'h14 && !r_ext_pend) w_ctl_l = w_make;
        if (r_byte == 8'h14 &&  r_ext_pend) w_ctl_r = w_make;
        if (r_byte == 8'h11 && !r_ext_pend) w_alt_l = w_make;
        if (r_byte == 8'h11 &&  r_ext_pend) w_alt_r = w_make;
        if (r_byte == 8'h58 && !r_ext_pend && w_make) w_caps = ~r_caps;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state    <= IDLE;
            r_byte     <= 8'h00;
            r_ext_pend <= 1'b0;
            r_brk_pend <= 1'b0;
            r_skip     <= '0;
            r_shl      <= 1'b0;
            r_shr      <= 1'b0;
            r_ctl_l    <= 1'b0;
            r_ctl_r    <= 1'b0;
            r_alt_l    <= 1'b0;
            r_alt_r    <= 1'b0;
            r_caps     <= 1'b0;
            r_pop_n    <= 1'b1;
            r_ev_valid <= 1'b0;
            r_ev_code  <= 8'h00;
            r_ev_ext   <= 1'b0;
            r_ev_break <= 1'b0;
            r_ev_mods  <= 4'h0;
            r_err_cnt  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            // Strobe and valid are registered copies of the next state so they never glitch.
            r_pop_n    <= (w_state_nxt != POP);
            r_ev_valid <= (w_state_nxt == EMIT);
            r_skip     <= w_skip_nxt;
            if (w_load_byte) r_byte <= ps2_data;
            if (w_clr_pfx) begin
                r_ext_pend <= 1'b0;
                r_brk_pend <= 1'b0;
            end else begin
                if (w_set_ext) r_ext_pend <= 1'b1;
                if (w_set_brk) r_brk_pend <= 1'b1;
            end
            if (w_err && (r_err_cnt != {ERR_W{1'b1}})) r_err_cnt <= r_err_cnt + 1'b1;
            if (w_emit) begin
                r_shl      <= w_shl;
                r_shr      <= w_shr;
                r_ctl_l    <= w_ctl_l;
                r_ctl_r    <= w_ctl_r;
                r_alt_l    <= w_alt_l;
                r_alt_r    <= w_alt_r;
                r_caps     <= w_caps;
                r_ev_code  <= r_byte;
                r_ev_ext   <= r_ext_pend;
                r_ev_break <= r_brk_pend;
                r_ev_mods  <= {w_caps, w_alt_l | w_alt_r, w_ctl_l | w_ctl_r, w_shl | w_shr};
            end
        end
    end

`ifdef TYPEMATIC_FILTER_EN
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_held_key <= 9'h000;
            r_held_vld <= 1'b0;
        end else if (w_emit) begin
            if (w_make) begin
                r_held_key <= {r_ext_pend, r_byte};
                r_held_vld <= 1'b1;
            end else if (r_held_key == {r_ext_pend, r_byte}) begin
                r_held_vld <= 1'b0;
            end
        end
    end
`endif

    assign ps2_nextdata_n = r_pop_n;
    assign ev_valid       = r_ev_valid;
    assign ev_code        = r_ev_code;
    assign ev_ext         = r_ev_ext;
    assign ev_break       = r_ev_break;
    assign ev_mods        = r_ev_mods;
    assign err_cnt        = r_err_cnt;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
`timescale 1ns/1ps
module tb_ps2_scancode_decoder;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
        logic [3:0] mods;
    } ev_t;

    logic       clk       = 1'b0;
    logic       clrn      = 1'b0;
    logic [7:0] ps2_data  = 8'h00;
    logic       ps2_ready = 1'b0;
    logic       ps2_nextdata_n;
    logic       ev_valid;
    logic       ev_ready  = 1'b1;
    logic [7:0] ev_code;
    logic       ev_ext;
    logic       ev_break;
    logic [3:0] ev_mods;
    logic [7:0] err_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] fifo_q[$];
    ev_t        exp_q[$];
    ev_t        obs_q[$];

    ps2_scancode_decoder #(.ERR_W(8), .PAUSE_SKIP(7)) dut (
        .clk            (clk),
        .clrn           (clrn),
        .ps2_data       (ps2_data),
        .ps2_ready      (ps2_ready),
        .ps2_nextdata_n (ps2_nextdata_n),
        .ev_valid       (ev_valid),
        .ev_ready       (ev_ready),
        .ev_code        (ev_code),
        .ev_ext         (ev_ext),
        .ev_break       (ev_break),
        .ev_mods        (ev_mods),
        .err_cnt        (err_cnt)
    );

    always #5 clk = ~clk;

    // Receiver FIFO model: pops on the strobe, presents its head byte away from the active edge.
    always @(negedge clk) begin
        if (!ps2_nextdata_n && fifo_q.size() != 0) void'(fifo_q.pop_front());
        ps2_ready = (fifo_q.size() != 0);
        ps2_data  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    end

    // Records every accepted event.
    always @(negedge clk) begin
        if (clrn && ev_valid && ev_ready) obs_q.push_back(ev_t'({ev_code, ev_ext, ev_break, ev_mods}));
    end

    task automatic send(input logic [7:0] b);
        fifo_q.push_back(b);
    endtask

    task automatic expect_ev(input logic [7:0] code, input logic ext, input logic brk, input logic [3:0] mods);
        exp_q.push_back(ev_t'({code, ext, brk, mods}));
    endtask

    task automatic drain();
        int n = 0;
        while ((fifo_q.size() != 0 || ev_valid) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        repeat (8) @(negedge clk);
        n_cmp++;
        if (n >= 5000) begin
            n_bad++;
            $display("FAIL drain_timeout: %0d bytes left after %0d cycles, required 0", fifo_q.size(), n);
        end
    endtask

    task automatic test_reset();
        clrn = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (ev_valid !== 1'b0)       begin n_bad++; $display("FAIL rst_valid: got %b want 0", ev_valid); end
        n_cmp++; if (ps2_nextdata_n !== 1'b1) begin n_bad++; $display("FAIL rst_pop_n: got %b want 1", ps2_nextdata_n); end
        n_cmp++; if (ev_code !== 8'h00)       begin n_bad++; $display("FAIL rst_code: got %h want 00", ev_code); end
        n_cmp++; if ({ev_ext, ev_break} !== 2'b00) begin n_bad++; $display("FAIL rst_flags: got %b want 00", {ev_ext, ev_break}); end
        n_cmp++; if (ev_mods !== 4'h0)        begin n_bad++; $display("FAIL rst_mods: got %b want 0000", ev_mods); end
        n_cmp++; if (err_cnt !== 8'h00)       begin n_bad++; $display("FAIL rst_err: got %0d want 0", err_cnt); end
        clrn = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        int lat = 0;
        obs_q.delete(); exp_q.delete();
        @(posedge clk); #1;
        send(8'h1C); expect_ev(8'h1C, 1'b0, 1'b0, 4'b0000);
        @(negedge clk); #1;
        while (lat < 10) begin
            @(posedge clk); #1;
            lat++;
            if (ev_valid) break;
        end
        n_cmp++;
        if (lat !== 3) begin n_bad++; $display("FAIL basic_latency: got %0d cycles want 3", lat); end
        send(8'hF0); send(8'h1C); expect_ev(8'h1C, 1'b0, 1'b1, 4'b0000);
        drain();
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL basic_count: got %0d events want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL basic_ev%0d: got %h/%b/%b/%b want %h/%b/%b/%b", i,
                obs_q[i].code, obs_q[i].ext, obs_q[i].brk, obs_q[i].mods, exp_q[i].code, exp_q[i].ext, exp_q[i].brk, exp_q[i].mods); end
        end
    endtask

    task automatic test_shift();
        obs_q.delete(); exp_q.delete();
        send(8'h12);              expect_ev(8'h12, 1'b0, 1'b0, 4'b0001);
        send(8'h1C);              expect_ev(8'h1C, 1'b0, 1'b0, 4'b0001);
        send(8'hF0); send(8'h12); expect_ev(8'h12, 1'b0, 1'b1, 4'b0000);
        send(8'h59);              expect_ev(8'h59, 1'b0, 1'b0, 4'b0001);
        send(8'hF0); send(8'h59); expect_ev(8'h59, 1'b0, 1'b1, 4'b0000);
        drain();
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL shift_count: got %0d events want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL shift_ev%0d: got %h/%b/%b/%b want %h/%b/%b/%b", i,
                obs_q[i].code, obs_q[i].ext, obs_q[i].brk, obs_q[i].mods, exp_q[i].code, exp_q[i].ext, exp_q[i].brk, exp_q[i].mods); end
        end
    endtask

    task automatic test_ext();
        obs_q.delete(); exp_q.delete();
        send(8'hE0); send(8'h75);               expect_ev(8'h75, 1'b1, 1'b0, 4'b0000);
        send(8'hE0); send(8'hF0); send(8'h75);  expect_ev(8'h75, 1'b1, 1'b1, 4'b0000);
        drain();
        n_cmp++;
        if (err_cnt !== 8'd0) begin n_bad++; $display("FAIL ext_err: got %0d want 0", err_cnt); end
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL ext_count: got %0d events want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL ext_ev%0d: got %h/%b/%b/%b want %h/%b/%b/%b", i,
                obs_q[i].code, obs_q[i].ext, obs_q[i].brk, obs_q[i].mods, exp_q[i].code, exp_q[i].ext, exp_q[i].brk, exp_q[i].mods); end
        end
    endtask

    task automatic test_pause();
        logic [7:0] seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        obs_q.delete(); exp_q.delete();
        foreach (seq[i]) send(seq[i]);
        send(8'h1C);              expect_ev(8'h1C, 1'b0, 1'b0, 4'b0000);
        send(8'hF0); send(8'h1C); expect_ev(8'h1C, 1'b0, 1'b1, 4'b0000);
        drain();
        n_cmp++;
        if (err_cnt !== 8'd0) begin n_bad++; $display("FAIL pause_err: got %0d want 0", err_cnt); end
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL pause_count: got %0d events want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL pause_ev%0d: got %h/%b/%b/%b want %h/%b/%b/%b", i,
                obs_q[i].code, obs_q[i].ext, obs_q[i].brk, obs_q[i].mods, exp_q[i].code, exp_q[i].ext, exp_q[i].brk, exp_q[i].mods); end
        end
    endtask

    task automatic test_errors();
        obs_q.delete(); exp_q.delete();
        send(8'hF0); send(8'hF0); send(8'h1C); expect_ev(8'h1C, 1'b0, 1'b1, 4'b0000);
        send(8'hF0); send(8'hAA); send(8'h1C); expect_ev(8'h1C, 1'b0, 1'b0, 4'b0000);
        send(8'hF0); send(8'h1C);              expect_ev(8'h1C, 1'b0, 1'b1, 4'b0000);
        send(8'h00); send(8'hFA);
        send(8'hE0); send(8'hE0); send(8'h75); expect_ev(8'h75, 1'b1, 1'b0, 4'b0000);
        send(8'hF0); send(8'hE0); send(8'h75); expect_ev(8'h75, 1'b1, 1'b1, 4'b0000);
        drain();
        n_cmp++;
        if (err_cnt !== 8'd4) begin n_bad++; $display("FAIL errors_cnt: got %0d want 4", err_cnt); end
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL errors_count: got %0d events want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL errors_ev%0d: got %h/%b/%b/%b want %h/%b/%b/%b", i,
                obs_q[i].code, obs_q[i].ext, obs_q[i].brk, obs_q[i].mods, exp_q[i].code, exp_q[i].ext, exp_q[i].brk, exp_q[i].mods); end
        end
    endtask

    task automatic test_mods();
        obs_q.delete(); exp_q.delete();
        send(8'h58);                           expect_ev(8'h58, 1'b0, 1'b0, 4'b1000);
        send(8'hF0); send(8'h58);              expect_ev(8'h58, 1'b0, 1'b1, 4'b1000);
        send(8'h58);                           expect_ev(8'h58, 1'b0, 1'b0, 4'b0000);
        send(8'hF0); send(8'h58);              expect_ev(8'h58, 1'b0, 1'b1, 4'b0000);
        send(8'hE0); send(8'h14);              expect_ev(8'h14, 1'b1, 1'b0, 4'b0010);
        send(8'h14);                           expect_ev(8'h14, 1'b0, 1'b0, 4'b0010);
        send(8'hE0); send(8'hF0); send(8'h14); expect_ev(8'h14, 1'b1, 1'b1, 4'b0010);
        send(8'hF0); send(8'h14);              expect_ev(8'h14, 1'b0, 1'b1, 4'b0000);
        send(8'h11);                           expect_ev(8'h11, 1'b0, 1'b0, 4'b0100);
        send(8'hF0); send(8'h11);              expect_ev(8'h11, 1'b0, 1'b1, 4'b0000);
        send(8'hE0); send(8'h11);              expect_ev(8'h11, 1'b1, 1'b0, 4'b0100);
        send(8'hE0); send(8'hF0); send(8'h11); expect_ev(8'h11, 1'b1, 1'b1, 4'b0000);
        drain();
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL mods_count: got %0d events want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL mods_ev%0d: got %h/%b/%b/%b want %h/%b/%b/%b", i,
                obs_q[i].code, obs_q[i].ext, obs_q[i].brk, obs_q[i].mods, exp_q[i].code, exp_q[i].ext, exp_q[i].brk, exp_q[i].mods); end
        end
    endtask

    task automatic test_typematic();
        obs_q.delete(); exp_q.delete();
        send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C);
        expect_ev(8'h1C, 1'b0, 1'b0, 4'b0000);
`ifndef TYPEMATIC_FILTER_EN
        expect_ev(8'h1C, 1'b0, 1'b0, 4'b0000);
        expect_ev(8'h1C, 1'b0, 1'b0, 4'b0000);
`endif
        expect_ev(8'h1C, 1'b0, 1'b1, 4'b0000);
        drain();
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL typematic_count: got %0d events want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL typematic_ev%0d: got %h/%b/%b/%b want %h/%b/%b/%b", i,
                obs_q[i].code, obs_q[i].ext, obs_q[i].brk, obs_q[i].mods, exp_q[i].code, exp_q[i].ext, exp_q[i].brk, exp_q[i].mods); end
        end
    endtask

    task automatic test_backpressure();
        int  n = 0;
        bit  bad_v = 0, bad_f = 0, bad_p = 0;
        ev_t held;
        obs_q.delete(); exp_q.delete();
        send(8'h12); expect_ev(8'h12, 1'b0, 1'b0, 4'b0001);
        drain();
        n_cmp++;
        if (obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin n_bad++;
            $display("FAIL bp_shift: got %0d events want 1 event 12/0/0/0001", obs_q.size()); end
        held = ev_t'({8'h1C, 1'b0, 1'b0, 4'b0001});
        ev_ready = 1'b0;
        send(8'h1C); send(8'h32); send(8'h21);
        while (!ev_valid && n < 50) begin @(negedge clk); n++; end
        n_cmp++;
        if (!ev_valid) begin n_bad++; $display("FAIL bp_wait: ev_valid=%b after %0d cycles want 1", ev_valid, n); end
        repeat (20) begin
            @(negedge clk);
            if (!ev_valid) bad_v = 1;
            if (ev_t'({ev_code, ev_ext, ev_break, ev_mods}) !== held) bad_f = 1;
            if (ps2_nextdata_n !== 1'b1) bad_p = 1;
        end
        n_cmp++; if (bad_v) begin n_bad++; $display("FAIL bp_valid: ev_valid dropped while ev_ready=0, want held high"); end
        n_cmp++; if (bad_f) begin n_bad++; $display("FAIL bp_fields: got %h/%b/%b/%b want 1c/0/0/0001", ev_code, ev_ext, ev_break, ev_mods); end
        n_cmp++; if (bad_p) begin n_bad++; $display("FAIL bp_pop: ps2_nextdata_n pulsed while stalled, want 1"); end
        n_cmp++; if (fifo_q.size() != 2) begin n_bad++; $display("FAIL bp_fifo: got %0d bytes queued want 2", fifo_q.size()); end
        @(posedge clk); #2;
        clrn = 1'b0;
        #1;
        n_cmp++; if (ev_valid !== 1'b0)       begin n_bad++; $display("FAIL bp_rst_valid: got %b want 0", ev_valid); end
        n_cmp++; if (ev_mods !== 4'b0000)     begin n_bad++; $display("FAIL bp_rst_mods: got %b want 0000", ev_mods); end
        n_cmp++; if (ev_code !== 8'h00)       begin n_bad++; $display("FAIL bp_rst_code: got %h want 00", ev_code); end
        n_cmp++; if (ps2_nextdata_n !== 1'b1) begin n_bad++; $display("FAIL bp_rst_pop: got %b want 1", ps2_nextdata_n); end
        fifo_q.delete();
        repeat (2) @(negedge clk);
        clrn = 1'b1;
        ev_ready = 1'b1;
        repeat (2) @(negedge clk);
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_saturation();
        obs_q.delete(); exp_q.delete();
        n_cmp++;
        if (err_cnt !== 8'd0) begin n_bad++; $display("FAIL sat_start: got %0d want 0", err_cnt); end
        for (int i = 0; i < 300; i++) send(8'hFF);
        drain();
        n_cmp++;
        if (err_cnt !== 8'd255) begin n_bad++; $display("FAIL sat_err: got %0d want 255", err_cnt); end
        n_cmp++;
        if (obs_q.size() != 0) begin n_bad++; $display("FAIL sat_events: got %0d events want 0", obs_q.size()); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_shift();
        test_ext();
        test_pause();
        test_errors();
        test_mods();
        test_typematic();
        test_backpressure();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
